// File: rtl/neighbor_table_ctrl.sv
// Neighbor-table sequencer: serialises update (search/overwrite/allocate),
// heartbeat-reset and best-Q scan requests onto the table's single slot port.
module neighbor_table_ctrl #(
   parameter int unsigned              WORD_WIDTH = 16,
   parameter int unsigned              NUM_SLOTS  = 32,
   parameter int unsigned              IDX_W      = 5,
   parameter logic [WORD_WIDTH-1:0]    MY_NODE_ID = 16'h000C
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  upd_valid,
   input  logic [WORD_WIDTH-1:0] upd_id,
   output logic                  upd_ready,
   output logic                  upd_hit,
   output logic                  upd_drop,
   input  logic                  hb_reset,
   input  logic                  best_req,
   output logic                  best_valid,
   output logic                  best_found,
   output logic [WORD_WIDTH-1:0] best_id,
   output logic [WORD_WIDTH-1:0] best_qvalue,
   output logic [IDX_W-1:0]      best_idx,
   output logic [IDX_W-1:0]      tbl_idx,
   output logic                  tbl_wr_en,
   output logic                  tbl_hb_reset,
   input  logic [WORD_WIDTH-1:0] tbl_rd_id,
   input  logic [WORD_WIDTH-1:0] tbl_rd_qvalue,
   output logic [IDX_W:0]        entry_count,
   output logic                  full
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEARCH, S_WRITE, S_HOLD, S_DROP, S_BEST, S_HBR, S_HBW
   } state_e;

   localparam logic [IDX_W:0]   SLOTS_C = (IDX_W+1)'(NUM_SLOTS);
   localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W:0]        cnt_q, cnt_d;
   logic                  hit_q, hit_d;
   logic                  hb_pend_q, hb_pend_d;
   logic                  best_pend_q, best_pend_d;
   logic                  bv_q, bv_d;
   logic                  bf_q, bf_d;
   logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
   logic [WORD_WIDTH-1:0] best_qv_q, best_qv_d;
   logic [IDX_W-1:0]      best_idx_q, best_idx_d;
   logic [WORD_WIDTH-1:0] run_id_q, run_id_d;
   logic [WORD_WIDTH-1:0] run_qv_q, run_qv_d;
   logic [IDX_W-1:0]      run_idx_q, run_idx_d;
   logic                  at_last;
   logic                  take;

   assign at_last = ({1'b0, idx_q} == (cnt_q - CNT_ONE));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         hit_q       <= 1'b0;
         hb_pend_q   <= 1'b0;
         best_pend_q <= 1'b0;
         bv_q        <= 1'b0;
         bf_q        <= 1'b0;
         best_id_q   <= '0;
         best_qv_q   <= '0;
         best_idx_q  <= '0;
         run_id_q    <= '0;
         run_qv_q    <= '0;
         run_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         hit_q       <= hit_d;
         hb_pend_q   <= hb_pend_d;
         best_pend_q <= best_pend_d;
         bv_q        <= bv_d;
         bf_q        <= bf_d;
         best_id_q   <= best_id_d;
         best_qv_q   <= best_qv_d;
         best_idx_q  <= best_idx_d;
         run_id_q    <= run_id_d;
         run_qv_q    <= run_qv_d;
         run_idx_q   <= run_idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      hit_d       = hit_q;
      hb_pend_d   = hb_pend_q | hb_reset;
      best_pend_d = best_pend_q | best_req;
      bv_d        = 1'b0;
      bf_d        = 1'b0;
      best_id_d   = best_id_q;
      best_qv_d   = best_qv_q;
      best_idx_d  = best_idx_q;
      run_id_d    = run_id_q;
      run_qv_d    = run_qv_q;
      run_idx_d   = run_idx_q;
      take        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // Same-cycle requests count as pending so arbitration sees them at once.
            if (hb_pend_q || hb_reset) begin
               hb_pend_d = 1'b0;
               state_d   = S_HBR;
            end else if (upd_valid) begin
               hit_d = 1'b0;
               idx_d = '0;
               if (upd_id == MY_NODE_ID)
                  state_d = S_DROP;
               else if (cnt_q == '0)
                  state_d = S_WRITE;
               else
                  state_d = S_SEARCH;
            end else if (best_pend_q || best_req) begin
               best_pend_d = 1'b0;
               idx_d       = '0;
               if (cnt_q == '0)
                  bv_d = 1'b1;
               else
                  state_d = S_BEST;
            end
         end
         S_SEARCH: begin
            if (tbl_rd_id == upd_id) begin
               hit_d   = 1'b1;
               state_d = S_WRITE;
            end else if (at_last) begin
               if (cnt_q < SLOTS_C) begin
                  idx_d   = cnt_q[IDX_W-1:0];
                  state_d = S_WRITE;
               end else begin
                  state_d = S_DROP;
               end
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         S_WRITE: state_d = S_HOLD;
         S_HOLD: begin
            if (!hit_q)
               cnt_d = cnt_q + CNT_ONE;
            state_d = S_IDLE;
         end
         S_DROP: state_d = S_IDLE;
         S_BEST: begin
            // Slot 0 seeds the running max; later slots replace only when strictly greater.
            take = (idx_q == '0) || (tbl_rd_qvalue > run_qv_q);
            if (take) begin
               run_id_d  = tbl_rd_id;
               run_qv_d  = tbl_rd_qvalue;
               run_idx_d = idx_q;
            end
            if (at_last) begin
               bv_d       = 1'b1;
               bf_d       = 1'b1;
               best_id_d  = take ? tbl_rd_id     : run_id_q;
               best_qv_d  = take ? tbl_rd_qvalue : run_qv_q;
               best_idx_d = take ? idx_q         : run_idx_q;
               state_d    = S_IDLE;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         S_HBR: begin
            cnt_d   = '0;
            state_d = S_HBW;
         end
         S_HBW: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      upd_ready    = 1'b0;
      upd_hit      = 1'b0;
      upd_drop     = 1'b0;
      tbl_wr_en    = 1'b0;
      tbl_hb_reset = 1'b0;
      unique case (state_q)
         S_WRITE: tbl_wr_en = 1'b1;
         S_HOLD: begin
            upd_ready = 1'b1;
            upd_hit   = hit_q;
         end
         S_DROP: begin
            upd_ready = 1'b1;
            upd_drop  = 1'b1;
         end
         S_HBR:   tbl_hb_reset = 1'b1;
         default: ;
      endcase
   end

   assign tbl_idx     = idx_q;
   assign entry_count = cnt_q;
   assign full        = (cnt_q == SLOTS_C);
   assign best_valid  = bv_q;
   assign best_found  = bf_q;
   assign best_id     = best_id_q;
   assign best_qvalue = best_qv_q;
   assign best_idx    = best_idx_q;

endmodule

// File: tb/tb_neighbor_table_ctrl.sv
// Bench for neighbor_table_ctrl: models the table and checks against a queue-based reference.
module tb_neighbor_table_ctrl;

   localparam int NS = 32;
   localparam logic [15:0] MY_ID = 16'h000C;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        upd_valid = 1'b0;
   logic [15:0] upd_id = '0;
   logic [15:0] upd_q = '0;
   logic        upd_ready, upd_hit, upd_drop;
   logic        hb_reset = 1'b0;
   logic        best_req = 1'b0;
   logic        best_valid, best_found;
   logic [15:0] best_id, best_qvalue;
   logic [4:0]  best_idx, tbl_idx;
   logic        tbl_wr_en, tbl_hb_reset;
   logic [15:0] tbl_rd_id, tbl_rd_qvalue;
   logic [5:0]  entry_count;
   logic        full;

   logic [15:0] mem_id [NS];
   logic [15:0] mem_q  [NS];

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   logic [15:0] ref_ids [$];
   logic [15:0] ref_q   [$];
   logic [15:0] last_id = '0;
   logic [15:0] last_qv = '0;
   logic [4:0]  last_idx = '0;

   always #5 clk = ~clk;

   neighbor_table_ctrl #(
      .WORD_WIDTH(16), .NUM_SLOTS(32), .IDX_W(5), .MY_NODE_ID(16'h000C)
   ) dut (
      .clk(clk), .nrst(nrst),
      .upd_valid(upd_valid), .upd_id(upd_id), .upd_ready(upd_ready),
      .upd_hit(upd_hit), .upd_drop(upd_drop),
      .hb_reset(hb_reset), .best_req(best_req),
      .best_valid(best_valid), .best_found(best_found), .best_id(best_id),
      .best_qvalue(best_qvalue), .best_idx(best_idx),
      .tbl_idx(tbl_idx), .tbl_wr_en(tbl_wr_en), .tbl_hb_reset(tbl_hb_reset),
      .tbl_rd_id(tbl_rd_id), .tbl_rd_qvalue(tbl_rd_qvalue),
      .entry_count(entry_count), .full(full)
   );

   // Table model: combinational read, write at the end of the write-request cycle.
   always @(posedge clk) begin
      if (tbl_wr_en) begin
         mem_id[tbl_idx] <= upd_id;
         mem_q[tbl_idx]  <= upd_q;
      end
   end
   assign tbl_rd_id     = mem_id[tbl_idx];
   assign tbl_rd_qvalue = mem_q[tbl_idx];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_update(input logic [15:0] id, input logic [15:0] q, input string tag);
      int pos, exp_lat, exp_slot, lat, wr_cnt, wr_idx, r_idx;
      logic exp_hit, exp_drop, got, r_hit, r_drop;
      pos = -1;
      foreach (ref_ids[i]) if (ref_ids[i] == id) pos = i;
      exp_hit = 1'b0; exp_drop = 1'b0; exp_slot = 0;
      if (id == MY_ID) begin
         exp_drop = 1'b1; exp_lat = 1;
      end else if (pos >= 0) begin
         exp_hit = 1'b1; exp_lat = pos + 3; exp_slot = pos; ref_q[pos] = q;
      end else if (ref_ids.size() < NS) begin
         exp_lat = ref_ids.size() + 2; exp_slot = ref_ids.size();
         ref_ids.push_back(id); ref_q.push_back(q);
      end else begin
         exp_drop = 1'b1; exp_lat = NS + 1;
      end
      @(posedge clk); #1;
      upd_valid = 1'b1; upd_id = id; upd_q = q;
      got = 1'b0; lat = 0; wr_cnt = 0; wr_idx = -1; r_idx = -1; r_hit = 1'b0; r_drop = 1'b0;
      while (!got && lat < 80) begin
         @(negedge clk);
         if (tbl_wr_en) begin wr_cnt++; wr_idx = 32'(tbl_idx); end
         if (upd_ready) begin
            got = 1'b1; r_hit = upd_hit; r_drop = upd_drop; r_idx = 32'(tbl_idx);
         end else lat++;
      end
      check($sformatf("%s ready", tag), 32'(got), 32'd1);
      check($sformatf("%s latency", tag), lat, exp_lat);
      check($sformatf("%s upd_hit", tag), 32'(r_hit), 32'(exp_hit));
      check($sformatf("%s upd_drop", tag), 32'(r_drop), 32'(exp_drop));
      check($sformatf("%s wr_pulses", tag), wr_cnt, exp_drop ? 0 : 1);
      if (!exp_drop) begin
         check($sformatf("%s wr_idx", tag), wr_idx, exp_slot);
         check($sformatf("%s hold_idx", tag), r_idx, exp_slot);
      end
      @(posedge clk); #1;
      upd_valid = 1'b0;
      @(negedge clk);
      check($sformatf("%s entry_count", tag), 32'(entry_count), ref_ids.size());
      check($sformatf("%s full", tag), 32'(full), 32'(ref_ids.size() == NS));
   endtask

   task automatic do_best(input string tag);
      int n, bi, lat, exp_lat;
      logic got;
      n = ref_ids.size();
      exp_lat = (n > 0) ? n + 1 : 1;
      if (n > 0) begin
         bi = 0;
         for (int i = 1; i < n; i++) if (ref_q[i] > ref_q[bi]) bi = i;
         last_id = ref_ids[bi]; last_qv = ref_q[bi]; last_idx = 5'(bi);
      end
      @(posedge clk); #1;
      best_req = 1'b1;
      got = 1'b0; lat = 0;
      while (!got && lat < 80) begin
         @(negedge clk);
         if (best_valid) got = 1'b1;
         else begin
            lat++;
            @(posedge clk); #1;
            best_req = 1'b0;
         end
      end
      best_req = 1'b0;
      check($sformatf("%s valid", tag), 32'(got), 32'd1);
      check($sformatf("%s latency", tag), lat, exp_lat);
      check($sformatf("%s found", tag), 32'(best_found), 32'(n > 0));
      check($sformatf("%s id", tag), 32'(best_id), 32'(last_id));
      check($sformatf("%s qvalue", tag), 32'(best_qvalue), 32'(last_qv));
      check($sformatf("%s idx", tag), 32'(best_idx), 32'(last_idx));
   endtask

   task automatic do_hb(input string tag);
      int lat;
      logic got;
      @(posedge clk); #1;
      hb_reset = 1'b1;
      got = 1'b0; lat = 0;
      while (!got && lat < 20) begin
         @(negedge clk);
         if (tbl_hb_reset) got = 1'b1;
         else begin
            lat++;
            @(posedge clk); #1;
            hb_reset = 1'b0;
         end
      end
      hb_reset = 1'b0;
      ref_ids.delete(); ref_q.delete();
      check($sformatf("%s seen", tag), 32'(got), 32'd1);
      check($sformatf("%s latency", tag), lat, 1);
      @(negedge clk);
      check($sformatf("%s one_cycle", tag), 32'(tbl_hb_reset), 32'd0);
      check($sformatf("%s entry_count", tag), 32'(entry_count), 32'd0);
   endtask

   initial begin
      int lat, hb_at, r_idx, k, r;
      logic got, r_hit;

      repeat (3) @(negedge clk);
      check("rst upd_ready", 32'(upd_ready), 32'd0);
      check("rst tbl_wr_en", 32'(tbl_wr_en), 32'd0);
      check("rst tbl_hb_reset", 32'(tbl_hb_reset), 32'd0);
      check("rst best_valid", 32'(best_valid), 32'd0);
      check("rst entry_count", 32'(entry_count), 32'd0);
      check("rst full", 32'(full), 32'd0);
      check("rst tbl_idx", 32'(tbl_idx), 32'd0);
      check("rst best_id", 32'(best_id), 32'd0);
      check("rst best_qvalue", 32'(best_qvalue), 32'd0);
      check("rst best_idx", 32'(best_idx), 32'd0);
      nrst = 1'b1;

      do_update(16'h0003, 16'h0011, "wr3");
      do_update(16'h0005, 16'h0022, "wr5");
      check("slot0 id", 32'(mem_id[0]), 32'h0003);
      check("slot1 id", 32'(mem_id[1]), 32'h0005);
      do_update(16'h0005, 16'h0055, "rewr5");
      check("slot1 q", 32'(mem_q[1]), 32'h0055);
      do_update(MY_ID, 16'h0077, "own");

      do_hb("hb1");
      do_update(16'h0021, 16'h0010, "bq0");
      do_update(16'h0022, 16'h0040, "bq1");
      do_update(16'h0023, 16'h0040, "bq2");
      do_update(16'h0024, 16'h0020, "bq3");
      do_best("best4");

      // hb_reset arriving while the update is searching
      @(posedge clk); #1;
      upd_valid = 1'b1; upd_id = 16'h0077; upd_q = 16'h0099;
      repeat (2) @(posedge clk);
      #1; hb_reset = 1'b1;
      @(posedge clk); #1; hb_reset = 1'b0;
      lat = 3; got = 1'b0; r_hit = 1'b0;
      while (!got && lat < 60) begin
         @(negedge clk);
         if (tbl_hb_reset) break;
         if (upd_ready) begin got = 1'b1; r_hit = upd_hit; end
         else begin lat++; @(posedge clk); #1; end
      end
      check("midhb ready", 32'(got), 32'd1);
      check("midhb latency", lat, ref_ids.size() + 2);
      check("midhb hit", 32'(r_hit), 32'd0);
      @(posedge clk); #1; upd_valid = 1'b0;
      hb_at = 0; got = 1'b0;
      while (!got && hb_at < 20) begin
         @(negedge clk);
         if (tbl_hb_reset) got = 1'b1; else begin hb_at++; @(posedge clk); end
      end
      ref_ids.delete(); ref_q.delete();
      check("midhb hb_seen", 32'(got), 32'd1);
      check("midhb hb_after_ready", hb_at, 1);
      @(negedge clk);
      check("midhb hb_one_cycle", 32'(tbl_hb_reset), 32'd0);
      check("midhb entry_count", 32'(entry_count), 32'd0);
      do_best("best_empty");

      // simultaneous hb_reset and update in IDLE
      @(posedge clk); #1;
      hb_reset = 1'b1; upd_valid = 1'b1; upd_id = 16'h0042; upd_q = 16'h0033;
      got = 1'b0; lat = 0; hb_at = -1; r_idx = -1; r_hit = 1'b1;
      while (!got && lat < 40) begin
         @(negedge clk);
         if (tbl_hb_reset && hb_at < 0) hb_at = lat;
         if (upd_ready) begin got = 1'b1; r_idx = 32'(tbl_idx); r_hit = upd_hit; end
         else begin lat++; @(posedge clk); #1; hb_reset = 1'b0; end
      end
      @(posedge clk); #1; upd_valid = 1'b0;
      @(negedge clk);
      ref_ids.delete(); ref_q.delete();
      ref_ids.push_back(16'h0042); ref_q.push_back(16'h0033);
      check("simul hb_at", hb_at, 1);
      check("simul ready", 32'(got), 32'd1);
      check("simul latency", lat, 5);
      check("simul slot", r_idx, 0);
      check("simul hit", 32'(r_hit), 32'd0);
      check("simul entry_count", 32'(entry_count), 32'd1);

      for (int i = 0; ref_ids.size() < NS; i++)
         do_update(16'h0100 + 16'(i), 16'(i * 3), $sformatf("fill%0d", i));
      check("fill full", 32'(full), 32'd1);
      do_update(16'h0200, 16'h0001, "overflow");
      do_best("best_full");

      do_hb("hb2");
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 29));
         if (r == 0) do_hb($sformatf("rhb%0d", i));
         else if (r <= 3) do_best($sformatf("rbest%0d", i));
         else begin
            k = int'($urandom_range(0, 39));
            do_update((k == 39) ? MY_ID : 16'h0400 + 16'(k),
                      16'($urandom_range(0, 7) * 16), $sformatf("rupd%0d", i));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/neighbor_table_ctrl.md
# neighbor_table_ctrl

Sequencer for the per-node neighbor table, sitting between QTableUpdate and the neighbor table. It turns neighbor-update requests into write pulses on the table's single write port. It first searches for an existing entry with the same node ID: on a match it overwrites that slot, otherwise it allocates the next free slot. It also serialises heartbeat resets and performs best-Q-value scans for cluster-head timeslot scheduling.

## Interface
- WORD_WIDTH, 16, width of node ID / Q-value words
- NUM_SLOTS, 32, table depth; must equal the table's entry count
- IDX_W, 5, slot index width, clog2(NUM_SLOTS)
- MY_NODE_ID, 16'h000C, own node ID; updates carrying it are dropped

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- upd_valid  in  1  update request; source holds it and upd_id (plus the data fields wired straight to the table) stable until upd_ready
- upd_id  in  WORD_WIDTH  node ID of the update
- upd_ready  out  1  one-cycle completion pulse
- upd_hit  out  1  with upd_ready: existing slot was overwritten
- upd_drop  out  1  with upd_ready: update discarded (own ID or table full)
- hb_reset  in  1  heartbeat reset request, single-cycle pulse
- best_req  in  1  start a best-neighbor scan, single-cycle pulse
- best_valid  out  1  one-cycle scan result strobe
- best_found  out  1  with best_valid: at least one entry existed
- best_id  out  WORD_WIDTH  ID of the max-Q entry (held until next scan)
- best_qvalue  out  WORD_WIDTH  its Q-value (held until next scan)
- best_idx  out  IDX_W  its slot (held until next scan)
- tbl_idx  out  IDX_W  drives the table's slot select (read and write)
- tbl_wr_en  out  1  table write request
- tbl_hb_reset  out  1  table heartbeat-reset request
- tbl_rd_id  in  WORD_WIDTH  table ID at tbl_idx (combinational read)
- tbl_rd_qvalue  in  WORD_WIDTH  table Q-value at tbl_idx
- entry_count  out  IDX_W+1  occupied slots; slots 0..entry_count-1 are valid
- full  out  1  entry_count == NUM_SLOTS

## Operation
- FSM states: IDLE, SEARCH, WRITE, HOLD, DROP, BEST, HBR, HBW. Each state lasts one cycle except SEARCH and BEST, which take one cycle per slot.
- IDLE arbitration priority:
  - pending hb_reset goes to HBR;
  - otherwise upd_valid goes to DROP if upd_id == MY_NODE_ID, to WRITE with tbl_idx=0 if entry_count==0, else to SEARCH with tbl_idx=0;
  - otherwise a pending best_req goes to BEST with tbl_idx=0.
- hb_reset and best_req arriving in any state set sticky pending flags. These flags are cleared when the request is serviced.
- SEARCH:
  - Compare tbl_rd_id with upd_id. On a match, go to WRITE with tbl_idx held and the hit flag set.
  - On a miss at the last valid slot: go to WRITE with tbl_idx=entry_count if entry_count<NUM_SLOTS, else go to DROP.
  - Otherwise increment tbl_idx.
- WRITE: tbl_wr_en=1.
- HOLD:
  - tbl_wr_en=0 and tbl_idx held, because the table commits the write in this cycle.
  - upd_ready=1, and upd_hit reflects the hit flag.
  - On an allocation (no hit), entry_count increments.
  - Next state is IDLE.
- DROP: upd_ready=1 and upd_drop=1, then IDLE.
- BEST:
  - Scan slots 0..entry_count-1 and keep the maximum tbl_rd_qvalue, compared unsigned.
  - On a tie, the lower index wins (replace only on strictly greater).
  - After the last slot, pulse best_valid=1 and best_found=1 and load best_id, best_qvalue and best_idx.
  - If entry_count==0, pulse best_valid=1 and best_found=0; best_* keep their old values.
- HBR: tbl_hb_reset=1 and entry_count<=0. HBW is an idle wait while the table executes its reset; then IDLE.
- tbl_wr_en and tbl_hb_reset are never asserted together.
- A transfer completes at the edge where upd_valid && upd_ready. The source may change its fields after that edge.

## Timing
- Reset values: state IDLE, tbl_idx=0, entry_count=0, full=0, pending flags=0. All strobes (upd_ready, upd_hit, upd_drop, best_valid, best_found, tbl_wr_en, tbl_hb_reset) are 0, and best_id, best_qvalue and best_idx are 0.
- nrst asserted mid-operation aborts the operation with no upd_ready; the table is reset by the same nrst.
- All outputs are registered or Moore-decoded from state; there are no input-to-output combinational paths.
- Update latency, measured from the IDLE cycle that sees upd_valid to the upd_ready cycle:
  - own ID: 1 cycle;
  - empty table: 2 cycles;
  - hit at slot i: i+3 cycles;
  - allocation with n entries: n+2 cycles;
  - full-table miss: NUM_SLOTS+1 cycles.
- Best scan latency with n>0 entries: best_valid n+1 cycles after the IDLE cycle that accepts the request; with n=0, 1 cycle.
- hb_reset: tbl_hb_reset asserts 1 cycle after IDLE accepts it, and IDLE is re-entered 2 cycles later. If hb_reset arrives during an update, it is serviced after upd_ready; a second upd_valid waits until the reset is done.
- Simultaneous hb_reset and upd_valid in IDLE: the reset is serviced first, and the update then allocates slot 0.

## Test plan
- After reset: write ID 0x0003 then ID 0x0005. Expect upd_ready at latency 2 then 3, upd_hit=0 both times, entry_count=2, table slots 0/1 = 0x0003/0x0005.
- Rewrite ID 0x0005 with a new Q-value. Expect upd_hit=1 at latency 4, tbl_idx=1 during WRITE/HOLD, entry_count unchanged at 2.
- Update with ID 0x000C. Expect upd_ready+upd_drop 1 cycle later, no tbl_wr_en pulse, entry_count unchanged.
- Fill 32 distinct IDs, then send a 33rd new ID. Expect full=1, upd_drop=1 after 33 cycles, no write.
- Q-values {0x10, 0x40, 0x40, 0x20} in slots 0-3, then best_req. Expect best_valid at +5 cycles, best_idx=1, best_qvalue=0x40, best_found=1.
- hb_reset asserted mid-SEARCH. Expect upd_ready first, then tbl_hb_reset for one cycle, entry_count=0. A following best_req then returns best_found=0.
